apb_rr_master: RTL
==================

// Module: apb_rr_master
// PURPOSE
//  APB master with a round-robin arbiter. It shares one APB bus (paddr/psel/penable/pwrite/pwdata/prdata) among NUM_REQ requesters.
//  Each accepted request becomes one SETUP+ACCESS transfer. Read data and completion are returned to the requester that owns the transfer.
//  The bus has no pready/pslverr, so every ACCESS phase lasts exactly one cycle.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  ADDR_W   32  address width
//  DATA_W   32  data width
// PORTS
//  pclk        in   1               bus clock; all logic on posedge
//  presetn     in   1               synchronous active-low reset
//  req_valid   in   NUM_REQ         per-requester request valid
//  req_write   in   NUM_REQ         1=write, 0=read
//  req_addr    in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata   in   NUM_REQ*DATA_W  packed write data, same packing
//  req_ready   out  NUM_REQ         one-hot accept; request taken when valid&ready
//  rsp_valid   out  NUM_REQ         one-cycle completion pulse to owner
//  rsp_rdata   out  DATA_W          read data, qualified by rsp_valid
//  busy        out  1               1 while state != IDLE
//  paddr       out  ADDR_W          APB address
//  psel        out  1               APB select
//  penable     out  1               APB enable
//  pwrite      out  1               APB direction
//  pwdata      out  DATA_W          APB write data
//  prdata      in   DATA_W          APB read data from slave
// BEHAVIOUR
//  Reset (presetn=0 at posedge):
//   - FSM goes to IDLE; RR pointer goes to 0.
//   - paddr, pwdata, pwrite, psel, penable, rsp_valid and rsp_rdata are all 0.
//   - req_ready is forced 0 while presetn=0.
//  FSM states: IDLE, SETUP, ACCESS.
//   - IDLE:   psel=0, penable=0.
//   - SETUP:  psel=1, penable=0. Always moves to ACCESS on the next edge.
//   - ACCESS: psel=1, penable=1.
//   - Leaving ACCESS: go to SETUP if a request is accepted in the same cycle, otherwise go to IDLE.
//  Arbitration:
//   - Combinational. Scan i = ptr, ptr+1, ... mod NUM_REQ; the first set req_valid wins.
//   - req_ready[g] = win[g] & (state==IDLE | state==ACCESS). All other bits are 0.
//   - On accept of g, ptr <= (g+1) mod NUM_REQ. With no accept, ptr is held.
//  Accept at edge T (valid&ready):
//   - paddr, pwrite and pwdata load from requester g; owner is registered as g.
//   - SETUP runs in cycle T+1 and ACCESS in T+2.
//   - Bus outputs hold their values from SETUP through the end of ACCESS. pwdata is 0 for reads.
//  Completion, at the edge ending ACCESS:
//   - rsp_valid[owner] is 1 for exactly one cycle (T+3).
//   - Read: rsp_rdata = prdata sampled at that edge. Write: rsp_rdata = 0.
//   - rsp_rdata holds its value until the next completion.
//  Back-to-back:
//   - An accept during ACCESS goes straight to SETUP. psel stays 1, penable drops to 0, and the new paddr etc. apply.
//   - Sustained throughput is one transfer per 2 cycles.
//  Requester rules:
//   - Inputs must hold stable while valid && !ready.
//   - Dropping valid before ready is allowed; that requester is no longer a candidate.
//  Reset mid-transfer: the transfer is abandoned with no rsp_valid. psel and penable are 0 after the reset edge.
//  All outputs are registered except req_ready.
// TESTING
//  1. Write: req0 valid, write=1, addr=0x10, wdata=0xA5A5A5A5.
//     -> ready0 in cycle 0; psel=1/penable=0 in cycle 1; penable=1 in cycle 2; rsp_valid[0] in cycle 3; rsp_rdata=0.
//  2. Read: req1 addr=0x20, slave drives prdata=0xDEADBEEF during ACCESS.
//     -> rsp_valid[1] pulse with rsp_rdata=0xDEADBEEF; pwrite=0 and pwdata=0 on the bus.
//  3. Contention: req0 and req1 asserted together from reset.
//     -> req0 granted first; req1 granted in req0's ACCESS cycle.
//     -> psel stays 1 for 4 cycles; penable pattern is 0,1,0,1.
//  4. Fairness: req0 held valid continuously, req1 valid continuously.
//     -> grants alternate 0,1,0,1; neither requester waits more than one transfer.
//  5. Wrap (NUM_REQ=3): only req2 valid, then only req0 valid.
//     -> ptr goes 0 -> 0 (req2 grant sets ptr=0) and req0 is granted next; pointer mod-3 wrap verified.
//  6. Reset: presetn low during ACCESS of a read.
//     -> no rsp_valid; psel=penable=0 and busy=0 after the edge.
//     -> the first grant after reset release goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/apb_rr_master.sv
// Round-robin APB master: shares one APB bus among NUM_REQ requesters, one SETUP+ACCESS per grant.
// Latency: accept at edge T -> SETUP T+1, ACCESS T+2, rsp_valid pulse T+3; one transfer per 2 cycles sustained.
// Backpressure: req_ready is a combinational one-hot grant, only offered in IDLE or ACCESS.
module apb_rr_master #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                        pclk,
   input  logic                        presetn,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic                        busy,
   output logic [ADDR_W-1:0]           paddr,
   output logic                        psel,
   output logic                        penable,
   output logic                        pwrite,
   output logic [DATA_W-1:0]           pwdata,
   input  logic [DATA_W-1:0]           prdata
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              write;
      logic [DATA_W-1:0] wdata;
   } xfer_t;

   state_t               state;
   state_t               state_nxt;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     owner;
   logic [PTR_W-1:0]     grant_idx;
   logic                 grant_any;
   logic [NUM_REQ-1:0]   win;
   logic [2*NUM_REQ-1:0] valid_dbl;
   logic                 accept_en;
   logic                 accept;
   xfer_t                sel;

   assign valid_dbl = {req_valid, req_valid};

   // Scan the doubled valid vector over the window [ptr, ptr+NUM_REQ); descending
   // order lets the candidate closest to ptr overwrite the others.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
         if (valid_dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + NUM_REQ)) begin
            grant_any = 1'b1;
            grant_idx = (j >= NUM_REQ) ? PTR_W'(j - NUM_REQ) : PTR_W'(j);
         end
      end
   end

   always_comb begin
      win = '0;
      sel = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         win[j] = grant_any && (grant_idx == PTR_W'(j));
         if (grant_idx == PTR_W'(j)) begin
            sel.addr  = req_addr[j*ADDR_W +: ADDR_W];
            sel.write = req_write[j];
            sel.wdata = req_wdata[j*DATA_W +: DATA_W];
         end
      end
   end

   assign accept_en = presetn && ((state == IDLE) || (state == ACCESS));
   assign req_ready = accept_en ? win : '0;
   assign accept    = accept_en && grant_any;

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? SETUP : IDLE;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  state_nxt = accept ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus strobes are registered from the next state so they line up with the FSM.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         psel      <= 1'b0;
         penable   <= 1'b0;
         busy      <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         owner     <= '0;
         ptr       <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         psel    <= (state_nxt != IDLE);
         penable <= (state_nxt == ACCESS);
         busy    <= (state_nxt != IDLE);
         if (accept) begin
            paddr  <= sel.addr;
            pwrite <= sel.write;
            pwdata <= sel.write ? sel.wdata : '0;
            owner  <= grant_idx;
            ptr    <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
         end
         rsp_valid <= '0;
         if (state == ACCESS) begin
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_rdata <= pwrite ? '0 : prdata;
         end
      end
   end

endmodule
